// File: rtl/uart_rx_deserializer.sv
// UART receive front end: 2-FF synchroniser, mid-bit sampling FSM and receive FIFO.
// Define UART_RX_PARITY_EN for 8E1 frames, which adds the parity_err output.
module uart_rx_deserializer #(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic                          sys_clk,
  input  logic                          sys_rstn,
  input  logic                          enable,
  input  logic [DIV_W-1:0]              baud_div,
  input  logic                          uart_rxd,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          rx_int,
  output logic                          overrun_int,
  input  logic                          overrun_clr,
  output logic                          frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                          parity_err,
`endif
  output logic                          busy
);

  // state    | meaning
  // S_IDLE   | line idle, waiting for a falling edge
  // S_START  | counting to mid start bit, rejects glitches
  // S_DATA   | sampling 8 data bits, LSB first
  // S_PARITY | sampling the even-parity bit (parity builds only)
  // S_STOP   | sampling stop bit, push byte or flag framing error
  // S_BREAK  | line held low after a framing error, wait for high

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  logic [1:0]       sync_q;
  logic             rxd_s;
  logic             rxd_s_q;
  logic             rx_fall;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] div_eff;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tick;
  logic             push_req;
  logic             frame_err_c;
`ifdef UART_RX_PARITY_EN
  logic             par_bad_q, par_bad_d;
  logic             parity_err_c;
`endif

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             full;
  logic             pop;
  logic             push_ok;
  logic             ovr_set;
  logic             overrun_q;

  assign rxd_s   = sync_q[1];
  assign rx_fall = rxd_s_q & ~rxd_s;
  assign div_eff = (baud_div < DIV_W'(4)) ? DIV_W'(4) : baud_div;
  assign tick    = (cnt_q == '0);

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      sync_q    <= 2'b11;
      rxd_s_q   <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      div_q     <= DIV_W'(4);
      bit_idx_q <= '0;
      shift_q   <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
`endif
    end else begin
      sync_q    <= {sync_q[0], uart_rxd};
      rxd_s_q   <= rxd_s;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    push_req    = 1'b0;
    frame_err_c = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_c = 1'b0;
`endif
    if ((state_q != S_IDLE) && !enable) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          // divisor is captured here so mid-frame baud_div changes are ignored
          if (enable && rx_fall) begin
            div_d   = div_eff;
            cnt_d   = (div_eff >> 1) - DIV_W'(1);
            state_d = S_START;
          end
        end
        S_START: begin
          if (tick) begin
            if (rxd_s) begin
              state_d = S_IDLE;
            end else begin
              state_d   = S_DATA;
              cnt_d     = div_q - DIV_W'(1);
              bit_idx_d = '0;
            end
          end else begin
            cnt_d = cnt_q - DIV_W'(1);
          end
        end
        S_DATA: begin
          if (tick) begin
            shift_d[bit_idx_q] = rxd_s;
            cnt_d              = div_q - DIV_W'(1);
            bit_idx_d          = bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end
          end else begin
            cnt_d = cnt_q - DIV_W'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (tick) begin
            par_bad_d = rxd_s ^ (^shift_q);
            cnt_d     = div_q - DIV_W'(1);
            state_d   = S_STOP;
          end else begin
            cnt_d = cnt_q - DIV_W'(1);
          end
        end
`endif
        S_STOP: begin
          if (tick) begin
            if (rxd_s) begin
`ifdef UART_RX_PARITY_EN
              if (par_bad_q) parity_err_c = 1'b1;
              else           push_req     = 1'b1;
`else
              push_req = 1'b1;
`endif
              state_d = S_IDLE;
            end else begin
              // a stop error masks any parity error in the same frame
              frame_err_c = 1'b1;
              state_d     = S_BREAK;
            end
          end else begin
            cnt_d = cnt_q - DIV_W'(1);
          end
        end
        S_BREAK: begin
          if (rxd_s) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign pop     = rx_valid & rx_ready;
  assign full    = (level_q == LW'(FIFO_DEPTH));
  // a pop frees the head slot in the same cycle, so a full FIFO still accepts
  assign push_ok = push_req & (~full | pop);
  assign ovr_set = push_req & full & ~pop;

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= shift_q;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
      if (ovr_set)          overrun_q <= 1'b1;
      else if (overrun_clr) overrun_q <= 1'b0;
    end
  end

  assign rx_data     = mem_q[rd_ptr_q];
  assign rx_valid    = (level_q != '0);
  assign fifo_level  = level_q;
  assign rx_int      = rx_valid;
  assign overrun_int = overrun_q;
  assign frame_err   = frame_err_c;
  assign busy        = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err  = parity_err_c;
`endif

endmodule
